cpu_sequencer: RTL and testbench

Phase and state sequencer for the 8-bit accumulator CPU. It sits around the instruction controller and closes its loop:
- Upstream of the controller, it supplies `phase` and `opcode`.
- Downstream of the controller, it consumes `ld_ir`, `inc_pc`, `ld_pc`, `halt` and `sel`. From these it maintains the instruction register and program counter and drives the memory address.

It also holds the halt state and counts retired instructions.

---
 rtl/cpu_sequencer.sv | 75 +++++++
 tb/tb_cpu_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Purpose: phase/state sequencer for the 8-bit accumulator CPU; holds IR, PC, halt flag and retired count.
// Latency: all outputs registered (strobes act at the end of their phase) except addr, which is combinational.
// Backpressure: none; halt freezes phase/IR/PC/count until resume, controller strobes ignored meanwhile.
module cpu_sequencer #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              sel,
    input  logic              ld_ir,
    input  logic              inc_pc,
    input  logic              ld_pc,
    input  logic              halt,
    input  logic              resume,
    output logic [2:0]        phase,
    output logic [2:0]        opcode,
    output logic [AWIDTH-1:0] ir_addr,
    output logic [AWIDTH-1:0] pc,
    output logic [AWIDTH-1:0] addr,
    output logic              halted,
    output logic [CNTW-1:0]   instr_count
);

    localparam logic [CNTW-1:0]   CNT_MAX = {CNTW{1'b1}};
    localparam logic [AWIDTH-1:0] PC_ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0]   CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic [DWIDTH-1:0] ir;

    assign opcode  = ir[DWIDTH-1:AWIDTH];
    assign ir_addr = ir[AWIDTH-1:0];

    // Memory address mux: PC during fetch, IR operand during execute.
    always_comb begin
        addr = sel ? pc : ir_addr;
    end

    // Phase, halt state, IR, PC and retired-count update; reset dominates, halt freezes everything but resume.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase       <= 3'd0;
            ir          <= '0;
            pc          <= '0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else if (halted) begin
            // Halt wins over a simultaneous resume so a still-asserted halt keeps us parked.
            if (resume && !halt) begin
                halted <= 1'b0;
                phase  <= phase + 3'd1;
                if (phase == 3'd7 && instr_count != CNT_MAX)
                    instr_count <= instr_count + CNT_ONE;
            end
        end else begin
            if (ld_ir)
                ir <= data_in;
            if (ld_pc)
                pc <= ir_addr;
            else if (inc_pc)
                pc <= pc + PC_ONE;
            if (halt) begin
                // Phase freezes where halt was seen; the HLT instruction is not retired here.
                halted <= 1'b1;
            end else begin
                phase <= phase + 3'd1;
                if (phase == 3'd7 && instr_count != CNT_MAX)
                    instr_count <= instr_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Purpose: directed self-checking bench for cpu_sequencer with hand-computed expectations.
// Latency: inputs driven 1ns after the rising edge, outputs sampled at that same point.
// Backpressure: not applicable; all stimulus is fixed-length, no open-ended waits.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        sel, ld_ir, inc_pc, ld_pc, halt, resume;
    logic [2:0]  phase, opcode;
    logic [4:0]  ir_addr, pc, addr;
    logic        halted;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;

    cpu_sequencer #(.AWIDTH(5), .DWIDTH(8), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel),
        .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc), .halt(halt), .resume(resume),
        .phase(phase), .opcode(opcode), .ir_addr(ir_addr), .pc(pc), .addr(addr),
        .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock with the given strobes, then strobes return low.
    task automatic tick(input logic i_ld_ir, input logic i_inc_pc, input logic i_ld_pc,
                        input logic i_halt, input logic i_resume);
        ld_ir  = i_ld_ir;
        inc_pc = i_inc_pc;
        ld_pc  = i_ld_pc;
        halt   = i_halt;
        resume = i_resume;
        @(posedge clk);
        #1;
        ld_ir = 1'b0; inc_pc = 1'b0; ld_pc = 1'b0; halt = 1'b0; resume = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; data_in = 8'h5A; sel = 1'b1;
        ld_ir = 1'b0; inc_pc = 1'b0; ld_pc = 1'b0; halt = 1'b0; resume = 1'b0;

        // Reset with random strobes for two cycles
        for (int i = 0; i < 2; i++) begin
            data_in = 8'($urandom);
            tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        check("rst_phase", phase, 0);
        check("rst_pc", pc, 0);
        check("rst_opcode", opcode, 0);
        check("rst_ir_addr", ir_addr, 0);
        check("rst_halted", halted, 0);
        check("rst_count", instr_count, 0);
        rst_n = 1'b1;

        // Fetch A7: ld_ir in phases 2,3, inc_pc in phase 4
        data_in = 8'hA7;
        idle(2);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        check("fetch_phase", phase, 5);
        check("fetch_opcode", opcode, 3'b101);
        check("fetch_ir_addr", ir_addr, 7);
        check("fetch_pc", pc, 1);
        idle(2);
        check("fetch_count_ph7", instr_count, 0);
        idle(1);
        check("fetch_wrap_phase", phase, 0);
        check("fetch_count", instr_count, 1);

        // JMP F3 with ld_pc and inc_pc together in phase 6
        data_in = 8'hF3;
        idle(2);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        idle(1);
        sel = 1'b1; #1;
        check("addr_sel_pc", addr, 1);
        sel = 1'b0; #1;
        check("addr_sel_ir", addr, 19);
        sel = 1'b1;
        idle(1);
        tick(0, 1, 1, 0, 0);
        check("jmp_pc", pc, 19);
        check("jmp_phase", phase, 7);
        idle(1);
        check("jmp_count", instr_count, 2);

        // PC wrap: JMP to 31 then increment
        data_in = 8'hFF;
        idle(2);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        check("wrap_pc31", pc, 31);
        tick(0, 1, 0, 0, 0);
        check("wrap_pc0", pc, 0);
        idle(2);
        check("wrap_count", instr_count, 3);

        // Halt with inc_pc at phase 4
        data_in = 8'h00;
        idle(2);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        check("hlt_phase_pre", phase, 4);
        tick(0, 1, 0, 1, 0);
        check("hlt_halted", halted, 1);
        check("hlt_phase", phase, 4);
        check("hlt_pc", pc, 1);
        for (int i = 0; i < 10; i++) begin
            data_in = 8'($urandom);
            tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
        check("hold_phase", phase, 4);
        check("hold_pc", pc, 1);
        check("hold_opcode", opcode, 0);
        check("hold_ir_addr", ir_addr, 0);
        check("hold_count", instr_count, 3);
        check("hold_halted", halted, 1);
        tick(0, 0, 0, 1, 1);
        check("halt_resume_halted", halted, 1);
        check("halt_resume_phase", phase, 4);
        tick(0, 0, 0, 0, 1);
        check("resume_halted", halted, 0);
        check("resume_phase", phase, 5);
        idle(3);
        check("resume_wrap_phase", phase, 0);
        check("resume_count", instr_count, 4);
        tick(0, 0, 0, 0, 1);
        check("resume_noop_phase", phase, 1);
        check("resume_noop_halted", halted, 0);

        // Reset mid-run at phase 6 with pc=9
        data_in = 8'h09;
        idle(1);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        idle(1);
        check("mid_pre_phase", phase, 6);
        check("mid_pre_pc", pc, 9);
        rst_n = 1'b0;
        tick(0, 1, 0, 1, 0);
        check("mid_phase", phase, 0);
        check("mid_pc", pc, 0);
        check("mid_halted", halted, 0);
        check("mid_opcode", opcode, 0);
        check("mid_count", instr_count, 0);
        rst_n = 1'b1;
        idle(1);
        check("post_rst_phase", phase, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
